// File: rtl/delta_sigma_pkg.sv
// Shared constants and helpers for the delta-sigma DAC.
// DELTA_SIGMA_ORDER2_EN selects the second-order CIFB modulator.
package delta_sigma_pkg;

  localparam int unsigned WIDTH_MIN    = 2;
  localparam int unsigned WIDTH_MAX    = 16;
  localparam int unsigned CHANNELS_MIN = 1;
  localparam int unsigned CHANNELS_MAX = 16;
  localparam int unsigned OSR_MIN      = 2;

`ifdef DELTA_SIGMA_ORDER2_EN
  localparam bit ORDER2 = 1'b1;
`else
  localparam bit ORDER2 = 1'b0;
`endif

  // State width per lane: accumulator (first order) or integrator (second order)
  function automatic int unsigned acc_width(input int unsigned width, input bit order2);
    return order2 ? width + 32'd4 : width + 32'd2;
  endfunction

  // Symmetric clamp to +/-(2^(width+2)-1)
  function automatic int sat(input int v, input int unsigned width);
    int lim;
    lim = int'((32'd1 << (width + 32'd2)) - 32'd1);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/delta_sigma_chan.sv
// One modulator lane: WIDTH-bit sample in, registered pulse-density bit out.
// DELTA_SIGMA_ORDER2_EN swaps the first-order accumulator for a CIFB pair.
module delta_sigma_chan
  import delta_sigma_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] active,
  output logic             dac_out
);

  localparam int unsigned AW = acc_width(WIDTH, ORDER2);

`ifdef DELTA_SIGMA_ORDER2_EN
  localparam int HALF = int'(32'd1 << (WIDTH - 32'd1));

  logic signed [AW-1:0] i1, i2, i1_nxt, i2_nxt;
  logic                 dac_nxt;
  int                   x_c, fb_c, s1_c, s2_c;

  // Two saturating integrators, both fed back from the registered output bit
  always_comb begin
    x_c    = int'(active) - HALF;
    fb_c   = dac_out ? HALF : -HALF;
    s1_c   = sat(int'(i1) + x_c - fb_c, WIDTH);
    s2_c   = sat(int'(i2) + s1_c - fb_c, WIDTH);
    i1_nxt = AW'(s1_c);
    i2_nxt = AW'(s2_c);
    dac_nxt = (s2_c >= 0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1      <= '0;
      i2      <= '0;
      dac_out <= 1'b0;
    end else begin
      i1      <= i1_nxt;
      i2      <= i2_nxt;
      dac_out <= dac_nxt;
    end
  end
`else
  logic [AW-1:0] acc, acc_nxt, delta;

  // When the MSB is set, adding 3<<WIDTH wraps to a subtraction of 2^WIDTH
  always_comb begin
    delta   = acc[AW-1] ? (AW'(2'd3) << WIDTH) : '0;
    acc_nxt = acc + AW'(active) + delta;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      dac_out <= 1'b0;
    end else begin
      acc     <= acc_nxt;
      dac_out <= acc[AW-1];
    end
  end
`endif

endmodule

// File: rtl/delta_sigma_dac.sv
// Multi-channel delta-sigma DAC: period counter, one-entry pending buffer, lanes.
// DELTA_SIGMA_ORDER2_EN selects second-order lanes; handshake is unchanged.
module delta_sigma_dac
  import delta_sigma_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned OSR      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [CHANNELS-1:0]       dac_out,
  output logic                      tick,
  output logic                      underrun
);

  localparam int unsigned DW    = CHANNELS * WIDTH;
  localparam int unsigned CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("delta_sigma_dac: WIDTH out of range");
  end
  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
    $error("delta_sigma_dac: CHANNELS out of range");
  end
  if (OSR < OSR_MIN) begin : g_bad_osr
    $error("delta_sigma_dac: OSR too small");
  end

  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    pend;
  logic [DW-1:0]    active;
  logic             pend_full;
  logic             accept;

  assign tick     = (cnt == CNT_LAST);
  assign s_ready  = !pend_full;
  assign underrun = tick && !pend_full;
  assign accept   = s_valid && !pend_full;

  // A tick with a full buffer drains it; s_ready is low then, so no accept collides
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      active    <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick && pend_full) begin
        active    <= pend;
        pend_full <= 1'b0;
      end else if (accept) begin
        pend      <= s_data;
        pend_full <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_chan
    delta_sigma_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .active  (active[k*WIDTH +: WIDTH]),
      .dac_out (dac_out[k])
    );
  end

endmodule

// File: tb/tb_delta_sigma_dac.sv
// Self-checking bench for delta_sigma_dac against a cycle-level arithmetic model.
module tb_delta_sigma_dac;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int OSR      = 8;
  localparam int DW       = CHANNELS * WIDTH;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [DW-1:0]       s_data = '0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [CHANNELS-1:0] dac_out;
  logic                tick;
  logic                underrun;

  int checks = 0;
  int errors = 0;

  delta_sigma_dac #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .OSR(OSR)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .dac_out(dac_out), .tick(tick), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Reference model: period phase n, pending queue, per-lane arithmetic
  int            n;
  logic [DW-1:0] pq[$];
  logic [DW-1:0] m_active;
  int            acc[CHANNELS];
  int            i1[CHANNELS];
  int            i2[CHANNELS];
  bit            m_dac[CHANNELS];

  function automatic int clamp(input int v);
    int lim = (1 << (WIDTH + 2)) - 1;
    return (v > lim) ? lim : ((v < -lim) ? -lim : v);
  endfunction

  task automatic model_reset();
    n = 0;
    pq.delete();
    m_active = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      acc[k] = 0; i1[k] = 0; i2[k] = 0; m_dac[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit tk, rdy;
    int a, x, fb;
    tk  = (n % OSR) == OSR - 1;
    rdy = (pq.size() == 0);
    for (int k = 0; k < CHANNELS; k++) begin
      a = int'(m_active[k*WIDTH +: WIDTH]);
`ifdef DELTA_SIGMA_ORDER2_EN
      x  = a - (1 << (WIDTH - 1));
      fb = m_dac[k] ? (1 << (WIDTH - 1)) : -(1 << (WIDTH - 1));
      i1[k] = clamp(i1[k] + x - fb);
      i2[k] = clamp(i2[k] + i1[k] - fb);
      m_dac[k] = (i2[k] >= 0);
`else
      x = 0; fb = 0;
      m_dac[k] = acc[k] >= (1 << (WIDTH + 1));
      acc[k] = (acc[k] + a + (m_dac[k] ? 3 * (1 << WIDTH) : 0)) % (1 << (WIDTH + 2));
`endif
    end
    if (tk && !rdy) m_active = pq.pop_front();
    if (s_valid && rdy) pq.push_back(s_data);
    n++;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_all();
    logic [CHANNELS-1:0] e;
    bit et;
    for (int k = 0; k < CHANNELS; k++) e[k] = m_dac[k];
    et = !rst && ((n % OSR) == OSR - 1);
    cmp("tick", 32'(tick), 32'(et));
    cmp("s_ready", 32'(s_ready), 32'(pq.size() == 0));
    cmp("underrun", 32'(underrun), 32'(et && pq.size() == 0));
    cmp("dac_out", 32'(dac_out), 32'(e));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    check_all();
  endtask

  // which: 0 = tick, 1 = s_ready
  task automatic wait_for(input int which, input int limit, output int cnt);
    cnt = 0;
    while (!((which == 0) ? tick : s_ready) && cnt < limit) begin
      cyc();
      cnt++;
    end
    if (!((which == 0) ? tick : s_ready)) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: which=%0d waited %0d cycles", which, cnt);
    end
  endtask

  int c;
  int ones[CHANNELS];
  int und_cnt;

  initial begin
    model_reset();
    repeat (3) cyc();
    cmp("reset_ready", 32'(s_ready), 32'd1);
    cmp("reset_dac", 32'(dac_out), 32'd0);
    cmp("reset_tick", 32'(tick), 32'd0);
    rst = 1'b0;

    // First tick lands on the last clock of the first period after release
    wait_for(0, 4 * OSR, c);
    cmp("release_to_tick", 32'(c), 32'(OSR - 1));

    // Single-sample handshake
    cyc();
    s_valid = 1'b1;
    s_data  = {CHANNELS{8'hAA}};
    cyc();
    s_valid = 1'b0;
    cmp("ready_drop", 32'(s_ready), 32'd0);
    wait_for(1, 4 * OSR, c);
    cmp("ready_return", 32'(c), 32'(OSR - 1));
    wait_for(0, 4 * OSR, c);
    cmp("underrun_after_drain", 32'(underrun), 32'd1);

    // Accept on the underrun tick: data parks in pend, moves on the next tick
    s_valid = 1'b1;
    s_data  = {CHANNELS{8'h33}};
    cyc();
    s_valid = 1'b0;
    cmp("accept_on_tick", 32'(s_ready), 32'd0);
    wait_for(0, 4 * OSR, c);
    cmp("no_underrun_full", 32'(underrun), 32'd0);
    cyc();
    cmp("ready_after_xfer", 32'(s_ready), 32'd1);

    // Constant streams: ch0=0, ch1=64, ch2=128, ch3=255
    s_valid = 1'b1;
    s_data  = {8'd255, 8'd128, 8'd64, 8'd0};
    repeat (3 * OSR + 16) cyc();
    und_cnt = 0;
    for (int k = 0; k < CHANNELS; k++) ones[k] = 0;
    for (int t = 0; t < 256; t++) begin
      cyc();
      if (underrun) und_cnt++;
      for (int k = 0; k < CHANNELS; k++) ones[k] += int'(dac_out[k]);
    end
    cmp("stream_underruns", 32'(und_cnt), 32'd0);
`ifdef DELTA_SIGMA_ORDER2_EN
    cmp_range("density_128_o2", ones[2], 126, 130);
`else
    cmp("density_0", 32'(ones[0]), 32'd0);
    cmp_range("density_64", ones[1], 63, 65);
    cmp_range("density_128", ones[2], 127, 129);
    cmp_range("density_255", ones[3], 254, 256);
`endif

    // Randomised traffic with an asynchronous reset partway through
    for (int t = 0; t < 1500; t++) begin
      s_valid = ($urandom_range(0, 3) == 0);
      s_data  = DW'($urandom());
      if (t == 700 + int'($urandom_range(0, 5))) begin
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        cmp("async_dac", 32'(dac_out), 32'd0);
        cmp("async_ready", 32'(s_ready), 32'd1);
        cmp("async_tick", 32'(tick), 32'd0);
        cmp("async_underrun", 32'(underrun), 32'd0);
        model_reset();
        repeat (2) cyc();
        rst = 1'b0;
        wait_for(0, 4 * OSR, c);
        cmp("release_to_tick_2", 32'(c), 32'(OSR - 1));
      end else begin
        cyc();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
